// File: rtl/dadda_pkg.sv
// -----------------------------------------------------------------------------
// dadda_pkg
// Shared types and helpers for the Dadda product accumulator.
//   acc_state_e : accumulator FSM states (IDLE / ACCUM / HOLD)
//   *_DEF       : default widths for PROD_W / ACC_W / CNT_W
//   acc_sum()   : wide add with carry-out and optional saturation
// Build option: DADDA_ACC_SAT_EN (consumed by dadda_acc_add).
// -----------------------------------------------------------------------------
package dadda_pkg;

  localparam int unsigned PROD_W_DEF = 32;
  localparam int unsigned ACC_W_DEF  = 40;
  localparam int unsigned CNT_W_DEF  = 8;

  // Widest accumulator the helper supports; operands are zero-extended to it.
  localparam int unsigned MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } acc_state_e;

  // Adds two w-bit values held in MAX_W-bit containers.
  // Result: bit MAX_W = carry out of bit w-1, bits [MAX_W-1:0] = w-bit sum
  // (wrapped, or all-ones when sat is set and a carry occurred). Bits between
  // w and MAX_W-1 are always zero.
  function automatic logic [MAX_W:0] acc_sum(
    input logic [MAX_W-1:0] a,
    input logic [MAX_W-1:0] b,
    input int unsigned      w,
    input logic             sat
  );
    logic [MAX_W:0] s;
    logic [MAX_W:0] sh;
    logic [MAX_W:0] mask;
    logic           carry;
    s     = {1'b0, a} + {1'b0, b};
    sh    = s >> w;
    carry = sh[0];
    mask  = ({{MAX_W{1'b0}}, 1'b1} << w) - {{MAX_W{1'b0}}, 1'b1};
    return {carry, (sat && carry) ? mask[MAX_W-1:0] : (s[MAX_W-1:0] & mask[MAX_W-1:0])};
  endfunction

endpackage

// File: rtl/dadda_acc_add.sv
// -----------------------------------------------------------------------------
// dadda_acc_add
// Combinational ACC_W+1-bit adder with carry out and saturation mux.
// Kept separate so it can be replaced by a compressor-tree adder.
//   i_acc   [ACC_W-1:0]  : current accumulator
//   i_prod  [PROD_W-1:0] : unsigned product (zero-extended)
//   o_sum   [ACC_W-1:0]  : wrapped or saturated sum
//   o_carry              : carry out of ACC_W bits
// Build option: DADDA_ACC_SAT_EN -> saturate to all-ones on carry.
// -----------------------------------------------------------------------------
module dadda_acc_add
  import dadda_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_carry
);

`ifdef DADDA_ACC_SAT_EN
  localparam logic SAT_EN = 1'b1;
`else
  localparam logic SAT_EN = 1'b0;
`endif

  logic [MAX_W:0]     w_res;
  logic [MAX_W:ACC_W] w_hi;

  always_comb w_res = acc_sum(MAX_W'(i_acc), MAX_W'(i_prod), ACC_W, SAT_EN);

  // Bits between ACC_W and MAX_W-1 are always zero, so OR-ing the whole
  // upper field yields exactly the carry flag.
  assign w_hi    = w_res[MAX_W:ACC_W];
  assign o_sum   = w_res[ACC_W-1:0];
  assign o_carry = |w_hi;

endmodule

// File: rtl/dadda_prod_accum.sv
// -----------------------------------------------------------------------------
// dadda_prod_accum
// Registered accumulator after the combinational 16x16 Dadda multiplier.
// Sums product beats into a group and presents the result over valid/ready.
//   clk, rst_n            : clock, synchronous active-low reset
//   prod_valid/prod_ready : product beat handshake
//   prod_data [PROD_W]    : unsigned product
//   prod_last             : beat closes the group
//   flush                 : close an open group without a beat
//   acc_valid/acc_ready   : result handshake
//   acc_data  [ACC_W]     : accumulated sum
//   acc_count [CNT_W]     : beats in group (saturating)
//   acc_ovf               : sticky carry-out flag for the group
// Build option: DADDA_ACC_SAT_EN (saturating vs wrapping accumulation).
// -----------------------------------------------------------------------------
module dadda_prod_accum
  import dadda_pkg::*;
#(
  parameter int unsigned PROD_W = PROD_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_valid,
  output logic              prod_ready,
  input  logic [PROD_W-1:0] prod_data,
  input  logic              prod_last,
  input  logic              flush,
  output logic              acc_valid,
  input  logic              acc_ready,
  output logic [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]  acc_count,
  output logic              acc_ovf
);

  acc_state_e       r_state, w_state_nxt;
  logic [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic             w_accept;
  logic [ACC_W-1:0] w_sum;
  logic             w_carry;

  dadda_acc_add #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W)
  ) u_add (
    .i_acc   (r_acc),
    .i_prod  (prod_data),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  assign prod_ready = (r_state != HOLD);
  assign acc_valid  = (r_state == HOLD);
  assign w_accept   = prod_valid && prod_ready;
  assign acc_data   = r_acc;
  assign acc_count  = r_cnt;
  assign acc_ovf    = r_ovf;

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    case (r_state)
      IDLE: begin
        // flush is not sampled here: an empty group is never produced.
        if (w_accept) begin
          w_acc_nxt   = ACC_W'(prod_data);
          w_cnt_nxt   = CNT_W'(1);
          w_ovf_nxt   = 1'b0;
          w_state_nxt = prod_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
          w_ovf_nxt = r_ovf | w_carry;
        end
        if ((w_accept && prod_last) || flush) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (acc_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

endmodule
